// File: rtl/fb_pkg.sv
// Shared frame-buffer layout constants and scan-out types.
// Used by the colour-cell writer and the colour scan-out reader.
package fb_pkg;

    localparam int FB_ADDR_W         = 14;
    localparam int COLOR_DATA_OFFSET = 8000;
    localparam int COLOR_CELLS_X     = 40;
    localparam int COLOR_CELLS_Y     = 25;
    localparam int BYTES_PER_ROW     = 40;
    localparam int ACTIVE_W          = 320;
    localparam int ACTIVE_H          = 200;

    // One 8-pixel cell: bitmap pattern plus foreground/background indices.
    typedef struct packed {
        logic [7:0] pattern;
        logic [3:0] fg;
        logic [3:0] bg;
    } cell_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_BMP,
        S_RD_COL,
        S_WAIT,
        S_HOLD
    } scan_state_t;

    // Bitmap byte address of cell cx on row y.
    function automatic logic [FB_ADDR_W-1:0] bmp_addr(input logic [7:0] y,
                                                      input logic [5:0] cx);
        return FB_ADDR_W'(y) * FB_ADDR_W'(BYTES_PER_ROW) + FB_ADDR_W'(cx);
    endfunction

    // Colour-attribute byte address; one attribute row covers 8 bitmap rows.
    function automatic logic [FB_ADDR_W-1:0] col_addr(input logic [7:0] y,
                                                      input logic [5:0] cx);
        return FB_ADDR_W'(COLOR_DATA_OFFSET)
             + FB_ADDR_W'(y >> 3) * FB_ADDR_W'(BYTES_PER_ROW)
             + FB_ADDR_W'(cx);
    endfunction

endpackage

// File: rtl/color_scanout_if.sv
// Frame-buffer read port: the scan-out drives address/strobe, memory returns data.
interface color_scanout_if;
    import fb_pkg::*;

    logic [FB_ADDR_W-1:0] fb_rd_addr;
    logic                 fb_rd_en;
    logic [7:0]           fb_rd_data;

    modport master (output fb_rd_addr, output fb_rd_en, input fb_rd_data);
    modport slave  (input fb_rd_addr, input fb_rd_en, output fb_rd_data);
endinterface

// File: rtl/color_scanout_cell_shifter.sv
// Per-cell pixel shifter: holds one cell, emits MSB-first fg/bg selection,
// and accepts the next cell on the same cycle the 8th pixel leaves.
module color_scanout_cell_shifter
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_flush,
    input  logic       i_load_req,
    input  cell_t      i_load_cell,
    output logic       o_load_ack,
    input  logic       i_shift,
    output logic       o_valid,
    output logic [3:0] o_color
);

    cell_t      r_cell;
    logic [2:0] r_bitcnt;
    logic       r_valid;
    logic       w_last;

    assign w_last     = r_valid & i_shift & (r_bitcnt == 3'd7);
    assign o_load_ack = i_load_req & ~i_flush & (~r_valid | w_last);
    assign o_valid    = r_valid;
    assign o_color    = r_cell.pattern[7] ? r_cell.fg : r_cell.bg;

    // Load a new cell when empty or draining; otherwise shift one pixel per request.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_cell   <= '0;
            r_bitcnt <= 3'd0;
            r_valid  <= 1'b0;
        end else if (o_load_ack) begin
            r_cell   <= i_load_cell;
            r_bitcnt <= 3'd0;
            r_valid  <= 1'b1;
        end else if (r_valid && i_shift) begin
            r_cell.pattern <= {r_cell.pattern[6:0], 1'b0};
            r_bitcnt       <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
                r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/color_scanout.sv
// Colour scan-out: prefetches bitmap + colour bytes per 8-pixel cell for one
// scanline and emits a 4-bit palette index per pixel enable.
module color_scanout
    import fb_pkg::*;
#(
    parameter int         RD_LATENCY   = 1,
    parameter logic [3:0] BORDER_COLOR = 4'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_line_start,
    input  logic [7:0]             i_line_y,
    input  logic                   i_pix_ce,
    color_scanout_if.master        fb,
    output logic [3:0]             o_pix_color,
    output logic                   o_pix_valid,
    output logic                   o_line_done,
    output logic                   o_underflow
);

    scan_state_t r_state, w_state_nxt;

    logic [7:0]            r_y;
    logic [5:0]            r_cell_x;
    logic [8:0]            r_pix_cnt;
    logic                  r_line_act;
    logic [RD_LATENCY:1]   r_vld_pipe;
    logic [RD_LATENCY:1]   r_col_pipe;
    logic [7:0]            r_bmp_byte;
    cell_t                 r_next;
    logic                  r_next_valid;

    logic                  w_start_ok;
    logic                  w_rd_bmp;
    logic                  w_rd_col;
    logic                  w_bmp_cap;
    logic                  w_col_cap;
    logic                  w_load_ack;
    logic                  w_sh_valid;
    logic [3:0]            w_sh_color;
    logic                  w_shift;

    assign w_start_ok = i_line_start & (i_line_y < 8'(ACTIVE_H));
    assign w_rd_bmp   = (r_state == S_RD_BMP);
    assign w_rd_col   = (r_state == S_RD_COL);
    // Returning read data is tagged so the bitmap byte and colour byte are
    // told apart without a latency-dependent counter.
    assign w_bmp_cap  = r_vld_pipe[RD_LATENCY] & ~r_col_pipe[RD_LATENCY];
    assign w_col_cap  = r_vld_pipe[RD_LATENCY] &  r_col_pipe[RD_LATENCY];
    assign w_shift    = i_pix_ce & ~i_line_start & r_line_act & w_sh_valid;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: one cell fetch per pass, holding while the next buffer is full.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = S_IDLE;
            S_RD_BMP: w_state_nxt = S_RD_COL;
            S_RD_COL: w_state_nxt = S_WAIT;
            S_WAIT:   if (w_col_cap) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (r_cell_x == 6'(COLOR_CELLS_X)) w_state_nxt = S_IDLE;
                else if (!r_next_valid)            w_state_nxt = S_RD_BMP;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        // A new line request aborts whatever is in progress.
        if (i_line_start)
            w_state_nxt = w_start_ok ? S_RD_BMP : S_IDLE;
    end

    // Read strobe and address, driven only in the two issue states.
    always_comb begin
        fb.fb_rd_en   = w_rd_bmp | w_rd_col;
        fb.fb_rd_addr = '0;
        if (w_rd_bmp)      fb.fb_rd_addr = bmp_addr(r_y, r_cell_x);
        else if (w_rd_col) fb.fb_rd_addr = col_addr(r_y, r_cell_x);
    end

    // Fetch datapath: read tag pipeline, bitmap holding byte and next-cell buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y          <= '0;
            r_cell_x     <= '0;
            r_vld_pipe   <= '0;
            r_col_pipe   <= '0;
            r_bmp_byte   <= '0;
            r_next       <= '0;
            r_next_valid <= 1'b0;
        end else if (i_line_start) begin
            // In-flight reads belong to the old line; drop their tags.
            r_vld_pipe   <= '0;
            r_col_pipe   <= '0;
            r_next_valid <= 1'b0;
            r_cell_x     <= '0;
            if (w_start_ok) r_y <= i_line_y;
        end else begin
            r_vld_pipe[1] <= w_rd_bmp | w_rd_col;
            r_col_pipe[1] <= w_rd_col;
            for (int k = 2; k <= RD_LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_col_pipe[k] <= r_col_pipe[k-1];
            end
            if (w_bmp_cap) r_bmp_byte <= fb.fb_rd_data;
            if (w_col_cap) begin
                r_next       <= '{pattern: r_bmp_byte,
                                  fg:      fb.fb_rd_data[7:4],
                                  bg:      fb.fb_rd_data[3:0]};
                r_next_valid <= 1'b1;
                r_cell_x     <= r_cell_x + 6'd1;
            end else if (w_load_ack) begin
                r_next_valid <= 1'b0;
            end
        end
    end

    color_scanout_cell_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (i_line_start),
        .i_load_req  (r_next_valid),
        .i_load_cell (r_next),
        .o_load_ack  (w_load_ack),
        .i_shift     (w_shift),
        .o_valid     (w_sh_valid),
        .o_color     (w_sh_color)
    );

    // Pixel output: shifter data, underflow border, or idle border per pixel enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_pix_color <= BORDER_COLOR;
            o_pix_valid <= 1'b0;
            o_line_done <= 1'b0;
            o_underflow <= 1'b0;
            r_pix_cnt   <= '0;
            r_line_act  <= 1'b0;
        end else begin
            o_pix_valid <= i_pix_ce;
            o_line_done <= 1'b0;
            o_underflow <= 1'b0;
            if (i_line_start) begin
                r_line_act <= w_start_ok;
                r_pix_cnt  <= '0;
                if (i_pix_ce) o_pix_color <= BORDER_COLOR;
            end else if (i_pix_ce) begin
                if (w_shift) begin
                    o_pix_color <= w_sh_color;
                    r_pix_cnt   <= r_pix_cnt + 9'd1;
                    if (r_pix_cnt == 9'(ACTIVE_W - 1)) begin
                        o_line_done <= 1'b1;
                        r_line_act  <= 1'b0;
                    end
                end else begin
                    o_pix_color <= BORDER_COLOR;
                    o_underflow <= r_line_act;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_scanout.sv
// Directed bench for color_scanout: latency-1 and latency-2 instances share stimulus.
module tb_color_scanout;
    import fb_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line_start = 1'b0;
    logic [7:0] line_y = 8'd0;
    logic       pix_ce = 1'b0;
    logic [3:0] col1, col2;
    logic       pv1, pv2, ld1, ld2, uf1, uf2;

    int total = 0;
    int bad   = 0;

    color_scanout_if bus1();
    color_scanout_if bus2();

    color_scanout #(.RD_LATENCY(1), .BORDER_COLOR(4'h0)) dut1 (
        .clk(clk), .reset(reset), .i_line_start(line_start), .i_line_y(line_y),
        .i_pix_ce(pix_ce), .fb(bus1), .o_pix_color(col1), .o_pix_valid(pv1),
        .o_line_done(ld1), .o_underflow(uf1));

    color_scanout #(.RD_LATENCY(2), .BORDER_COLOR(4'h0)) dut2 (
        .clk(clk), .reset(reset), .i_line_start(line_start), .i_line_y(line_y),
        .i_pix_ce(pix_ce), .fb(bus2), .o_pix_color(col2), .o_pix_valid(pv2),
        .o_line_done(ld2), .o_underflow(uf2));

    always #5 clk = ~clk;

    // Frame buffer with one- and two-cycle read pipelines.
    logic [7:0] mem [0:16383];
    logic [7:0] m1_d, m2_a, m2_b;
    always @(posedge clk) begin
        m1_d <= mem[bus1.fb_rd_addr];
        m2_a <= mem[bus2.fb_rd_addr];
        m2_b <= m2_a;
    end
    assign bus1.fb_rd_data = m1_d;
    assign bus2.fb_rd_data = m2_b;

    // Output monitors.
    logic [3:0] q1c[$], q2c[$];
    bit         q1u[$], q2u[$];
    int         rd_log[$];
    int         ld1_cnt, ld1_at, ld2_cnt, ld2_at;
    always @(negedge clk) begin
        if (pv1) begin q1c.push_back(col1); q1u.push_back(uf1); end
        if (pv2) begin q2c.push_back(col2); q2u.push_back(uf2); end
        if (ld1) begin ld1_cnt++; ld1_at = q1c.size(); end
        if (ld2) begin ld2_cnt++; ld2_at = q2c.size(); end
        if (bus1.fb_rd_en) rd_log.push_back(int'(bus1.fb_rd_addr));
    end

    function automatic logic [3:0] exp_pix(input int y, input int p);
        int cx, b;
        logic [7:0] bm, cl;
        cx = p / 8;
        b  = 7 - (p % 8);
        bm = mem[14'(y * 40 + cx)];
        cl = mem[14'(8000 + (y / 8) * 40 + cx)];
        return bm[b] ? cl[7:4] : cl[3:0];
    endfunction

    function automatic int stream_errs(input logic [3:0] q[$], input int base,
                                       input int y, input int n);
        int e = 0;
        for (int p = 0; p < n; p++)
            if (base + p >= q.size() || q[base + p] !== exp_pix(y, p)) e++;
        return e;
    endfunction

    function automatic int ones(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    function automatic int nonborder(input logic [3:0] q[$]);
        int s = 0;
        foreach (q[i]) if (q[i] !== 4'h0) s++;
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr();
        q1c.delete(); q1u.delete(); q2c.delete(); q2u.delete(); rd_log.delete();
        ld1_cnt = 0; ld1_at = -1; ld2_cnt = 0; ld2_at = -1;
    endtask

    task automatic start_line(input logic [7:0] y);
        line_start = 1'b1; line_y = y;
        tick(1);
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total++; if (col1 !== 4'h0) begin bad++; $display("FAIL reset_color: got %0h want 0", col1); end
        total++; if (pv1 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", pv1); end
        total++; if (ld1 !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", ld1); end
        total++; if (uf1 !== 1'b0) begin bad++; $display("FAIL reset_uf: got %0b want 0", uf1); end
        total++; if (bus1.fb_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %0b want 0", bus1.fb_rd_en); end
        total++; if (bus1.fb_rd_addr !== 14'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bus1.fb_rd_addr); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        logic [31:0] first8;
        clr();
        start_line(8'd0);
        tick(9);
        pix_ce = 1'b1; tick(320); pix_ce = 1'b0;
        tick(4);
        first8 = {q1c[0], q1c[1], q1c[2], q1c[3], q1c[4], q1c[5], q1c[6], q1c[7]};
        total++; if (first8 !== 32'h3C3CC3C3) begin bad++; $display("FAIL basic_first8: got %h want 3c3cc3c3", first8); end
        total++; if (q1c.size() !== 320) begin bad++; $display("FAIL basic_pv: got %0d want 320", q1c.size()); end
        total++; if (stream_errs(q1c, 0, 0, 320) !== 0) begin bad++; $display("FAIL basic_stream: got %0d bad pixels want 0", stream_errs(q1c, 0, 0, 320)); end
        total++; if (ones(q1u) !== 0) begin bad++; $display("FAIL basic_uf: got %0d want 0", ones(q1u)); end
        total++; if (ld1_cnt !== 1 || ld1_at !== 320) begin bad++; $display("FAIL basic_done: got cnt=%0d at=%0d want cnt=1 at=320", ld1_cnt, ld1_at); end
    endtask

    task automatic test_last_row();
        int oe = 0;
        clr();
        start_line(8'd199);
        tick(9);
        pix_ce = 1'b1; tick(320); pix_ce = 1'b0;
        tick(4);
        for (int k = 0; k < 40; k++)
            if (rd_log.size() < 80 || rd_log[2*k] !== 7960 + k || rd_log[2*k+1] !== 8960 + k) oe++;
        total++; if (rd_log.size() !== 80) begin bad++; $display("FAIL last_nreads: got %0d want 80", rd_log.size()); end
        total++; if (oe !== 0) begin bad++; $display("FAIL last_addr_order: got %0d bad cells want 0", oe); end
        total++; if (ld1_cnt !== 1 || ld1_at !== 320) begin bad++; $display("FAIL last_done: got cnt=%0d at=%0d want cnt=1 at=320", ld1_cnt, ld1_at); end
        total++; if (stream_errs(q1c, 0, 199, 320) !== 0) begin bad++; $display("FAIL last_stream: got %0d bad pixels want 0", stream_errs(q1c, 0, 199, 320)); end
    endtask

    task automatic test_underflow();
        clr();
        start_line(8'd3);
        tick(1);
        pix_ce = 1'b1; tick(323); pix_ce = 1'b0;
        tick(4);
        total++; if (q1c.size() !== 323) begin bad++; $display("FAIL uf_pv: got %0d want 323", q1c.size()); end
        total++; if (q1c[0] !== 4'h0 || q1u[0] !== 1'b1) begin bad++; $display("FAIL uf_first: got color=%0h uf=%0b want color=0 uf=1", q1c[0], q1u[0]); end
        total++; if (ones(q1u) !== 3) begin bad++; $display("FAIL uf_count: got %0d want 3", ones(q1u)); end
        total++; if (stream_errs(q1c, 3, 3, 320) !== 0) begin bad++; $display("FAIL uf_stream: got %0d bad pixels want 0", stream_errs(q1c, 3, 3, 320)); end
        total++; if (ld1_cnt !== 1) begin bad++; $display("FAIL uf_done: got %0d want 1", ld1_cnt); end
    endtask

    task automatic test_restart();
        clr();
        start_line(8'd5);
        tick(9);
        pix_ce = 1'b1; tick(100);
        line_start = 1'b1; line_y = 8'd8;
        tick(1);
        line_start = 1'b0; pix_ce = 1'b0;
        rd_log.delete();
        tick(9);
        pix_ce = 1'b1; tick(320); pix_ce = 1'b0;
        tick(4);
        total++; if (rd_log.size() < 2 || rd_log[0] !== 320 || rd_log[1] !== 8040) begin bad++; $display("FAIL restart_addr: got %0d/%0d want 320/8040", rd_log[0], rd_log[1]); end
        total++; if (rd_log.size() !== 80) begin bad++; $display("FAIL restart_nreads: got %0d want 80", rd_log.size()); end
        total++; if (q1c.size() !== 421) begin bad++; $display("FAIL restart_pv: got %0d want 421", q1c.size()); end
        total++; if (stream_errs(q1c, 0, 5, 100) !== 0) begin bad++; $display("FAIL restart_old: got %0d bad pixels want 0", stream_errs(q1c, 0, 5, 100)); end
        total++; if (q1c[100] !== 4'h0 || q1u[100] !== 1'b0) begin bad++; $display("FAIL restart_coincident: got color=%0h uf=%0b want color=0 uf=0", q1c[100], q1u[100]); end
        total++; if (stream_errs(q1c, 101, 8, 320) !== 0) begin bad++; $display("FAIL restart_new: got %0d bad pixels want 0", stream_errs(q1c, 101, 8, 320)); end
        total++; if (ones(q1u) !== 0) begin bad++; $display("FAIL restart_uf: got %0d want 0", ones(q1u)); end
        total++; if (ld1_cnt !== 1 || ld1_at !== 421) begin bad++; $display("FAIL restart_done: got cnt=%0d at=%0d want cnt=1 at=421", ld1_cnt, ld1_at); end
    endtask

    task automatic test_invalid_line();
        clr();
        start_line(8'd200);
        tick(2);
        pix_ce = 1'b1; tick(5); pix_ce = 1'b0;
        tick(4);
        total++; if (rd_log.size() !== 0) begin bad++; $display("FAIL inv_reads: got %0d want 0", rd_log.size()); end
        total++; if (q1c.size() !== 5) begin bad++; $display("FAIL inv_pv: got %0d want 5", q1c.size()); end
        total++; if (nonborder(q1c) !== 0) begin bad++; $display("FAIL inv_color: got %0d non-border want 0", nonborder(q1c)); end
        total++; if (ones(q1u) !== 0) begin bad++; $display("FAIL inv_uf: got %0d want 0", ones(q1u)); end
    endtask

    task automatic test_reset_mid();
        clr();
        start_line(8'd10);
        tick(9);
        pix_ce = 1'b1; tick(50);
        reset = 1'b1;
        tick(1);
        total++; if (col1 !== 4'h0) begin bad++; $display("FAIL rstmid_color: got %0h want 0", col1); end
        total++; if (pv1 !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", pv1); end
        total++; if (ld1 !== 1'b0 || uf1 !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got done=%0b uf=%0b want 0/0", ld1, uf1); end
        total++; if (bus1.fb_rd_en !== 1'b0 || bus1.fb_rd_addr !== 14'd0) begin bad++; $display("FAIL rstmid_rd: got en=%0b addr=%0d want 0/0", bus1.fb_rd_en, bus1.fb_rd_addr); end
        reset = 1'b0;
        clr();
        tick(10); pix_ce = 1'b0;
        tick(4);
        total++; if (rd_log.size() !== 0) begin bad++; $display("FAIL rstmid_idle: got %0d reads want 0", rd_log.size()); end
        total++; if (q1c.size() !== 10 || nonborder(q1c) !== 0 || ones(q1u) !== 0) begin bad++; $display("FAIL rstmid_after: got pv=%0d nb=%0d uf=%0d want 10/0/0", q1c.size(), nonborder(q1c), ones(q1u)); end
    endtask

    task automatic test_lat2();
        clr();
        start_line(8'd100);
        tick(9);
        pix_ce = 1'b1; tick(320); pix_ce = 1'b0;
        tick(6);
        total++; if (q2c.size() !== 320) begin bad++; $display("FAIL lat2_pv: got %0d want 320", q2c.size()); end
        total++; if (ones(q2u) !== 0) begin bad++; $display("FAIL lat2_uf: got %0d want 0", ones(q2u)); end
        total++; if (ld2_cnt !== 1 || ld2_at !== 320) begin bad++; $display("FAIL lat2_done: got cnt=%0d at=%0d want cnt=1 at=320", ld2_cnt, ld2_at); end
        total++; if (stream_errs(q2c, 0, 100, 320) !== 0) begin bad++; $display("FAIL lat2_stream: got %0d bad pixels want 0", stream_errs(q2c, 0, 100, 320)); end
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 8'((a * 37) ^ (a >> 5));
        mem[0]    = 8'hA5;
        mem[8000] = 8'h3C;
        test_reset();
        test_basic();
        test_last_row();
        test_underflow();
        test_restart();
        test_invalid_line();
        test_reset_mid();
        test_lat2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_scanout.md
Name: color_scanout

Overview:
- Read-side counterpart of the colour-cell write path.
- Walks one active scanline of the 320x200 1bpp bitmap plus the 40x25 colour-attribute area in the shared frame buffer.
- Prefetches bitmap and colour bytes per 8-pixel cell and emits one 4-bit palette index per pixel-clock enable.
- Sits between the video timing generator and the display palette/DAC stage; the top level routes fb_rd_* to the displayed buffer (A/B).

Parameters:
- RD_LATENCY, 1, frame-buffer read data valid this many cycles after fb_rd_en (1 or 2 supported).
- BORDER_COLOR, 4'h0, index emitted outside the active line or on underflow.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- line_start  in  1  single-cycle pulse; begin prefetch for line_y
- line_y  in  8  active row 0-199, sampled with line_start
- pix_ce  in  1  pixel enable from timing generator; one pixel consumed per assertion
- fb_rd_addr  out  14  frame-buffer byte address
- fb_rd_en  out  1  read strobe, one cycle per byte
- fb_rd_data  in  8  read data, valid RD_LATENCY cycles after fb_rd_en
- pix_color  out  4  palette index
- pix_valid  out  1  pulses the cycle after each pix_ce
- line_done  out  1  pulse with the 320th pixel's pix_valid
- underflow  out  1  pulse: pix_ce with no cell data available

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, buffers empty, pix_color = BORDER_COLOR (0).
- line_start with line_y < 200: latch y, clear cell_x to 0, flush shifter and next buffer, enter RD_BMP. Accepted in any state, so it aborts any line in progress.
- line_start with line_y >= 200: ignored, FSM stays or returns to IDLE.
- Address arithmetic:
  - Bitmap: y*40 + cell_x.
  - Colour: 8000 + (y>>3)*40 + cell_x.
  - Compute in 14 bits; max values are 7999 and 8999.
- FSM states:
  - IDLE
  - RD_BMP: issue bitmap read.
  - RD_COL: issue colour read on the next cycle.
  - WAIT: count RD_LATENCY, capture bitmap then colour data into the next buffer, set next_valid, increment cell_x.
  - HOLD: wait while next_valid = 1 and cell_x < 40. Go to RD_BMP when next_valid clears. Go to IDLE when cell_x = 40.
- Shifter:
  - Fields: pattern[7:0], fg = colour[7:4], bg = colour[3:0], bitcnt[2:0], shift_valid.
  - Loads from the next buffer when it is empty, or on the same cycle its 8th pixel is consumed (no bubble). The load clears next_valid.
- Pixel output on pix_ce:
  - shift_valid: pix_color <= pattern[7] ? fg : bg. MSB is the leftmost pixel. Shift left, increment bitcnt, pix_valid <= 1.
  - Shifter empty and line still active: pix_color <= BORDER_COLOR, pix_valid <= 1, underflow <= 1.
  - After 320 pixels, or in IDLE: BORDER_COLOR, pix_valid <= 1, no underflow.
- Pixel counter:
  - 9-bit, counts 0..320. line_done asserts with the pixel at count 319.
- Throughput:
  - One cell fetch takes 3 + RD_LATENCY cycles, which is ≤ 8 pix_ce periods at the full clock rate.
  - The timing generator guarantees ≥ 2*(3+RD_LATENCY) cycles from line_start to the first pix_ce, so two cells are buffered.
- Simultaneous line_start and pix_ce: line_start takes priority. The pixel is output as BORDER_COLOR with no underflow.
- fb_rd_en: at most one per cycle, never during IDLE or HOLD.

Decomposition:
- Package fb_pkg:
  - FB_ADDR_W = 14
  - COLOR_DATA_OFFSET = 8000
  - COLOR_CELLS_X = 40, COLOR_CELLS_Y = 25
  - BYTES_PER_ROW = 40
  - ACTIVE_W = 320, ACTIVE_H = 200
  - typedef cell_t {pattern, fg, bg}
  - enum scan_state_t
- Package users: this block and the colour-cell writer.
- Sub-module cell_shifter: shift register, bitcnt, fg/bg select, load handshake (load_req/load_ack).

Test Plan:
- Bitmap byte 0 = 8'hA5, byte 8000 = 8'h3C; line_start y=0, then pix_ce every cycle after 10 cycles -> first 8 pix_color = 3,C,3,C,C,3,C,3.
- line_y = 199 -> bitmap addrs 7960..7999 and colour addrs 8960..8999 issued in order, 80 reads total, line_done on the 320th pix_valid.
- pix_ce asserted 2 cycles after line_start -> underflow pulse, pix_color = BORDER_COLOR; pixels are correct once prefetch lands.
- Second line_start at pixel 100 with y=8 -> fetch restarts at addrs 320 and 8040; no stale pixels emitted from the old line.
- line_y = 200 -> no fb_rd_en; pix_ce yields BORDER_COLOR with underflow = 0. Reset asserted mid-line -> all outputs 0 the next cycle and FSM in IDLE.
- RD_LATENCY = 2, pix_ce every cycle for a full line -> no underflow, 320 pix_valid pulses.
